tx_buffered: RTL and testbench
==============================

Name: tx_buffered

Overview:
- Parametrised serial flit transmitter for router output ports; successor to the single-flit serial tx.
- Accepts parallel flits into an internal FIFO of DEPTH entries.
- Serialises each flit onto a 1-bit channel as: start bit, WIDTH data bits (LSB first), optional even-parity bit.
- Launches only when the downstream channel is not busy, and enforces a programmable idle gap between frames.

Parameters:
- WIDTH, 8: flit data width in bits (>=1).
- DEPTH, 4: FIFO entries, power of two (>=2).
- PARITY_EN, 0: 1 appends an even-parity bit after the data bits.
- GAP, 0: minimum idle cycles between the last bit of one frame and the next start bit (0..255).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  push request for din.
- din  in  WIDTH  flit to enqueue.
- full  out  1  FIFO holds DEPTH entries.
- count  out  clog2(DEPTH+1)  FIFO occupancy.
- overflow  out  1  sticky; set when wr_en is asserted while full.
- channel_busy  in  1  downstream channel occupied; sampled only in IDLE.
- serial_out  out  1  serial line; 0 whenever not transmitting.
- tx_active  out  1  high exactly during the frame bits.
- tx_busy  out  1  tx_active | channel_busy | (state==GAP).
- frame_done  out  1  one-cycle pulse on the cycle after the last frame bit.

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFO emptied: count=0, full=0.
  - overflow=0, tx_active=0, serial_out=0, frame_done=0, state=IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no partial-frame recovery.
- Frame length F = 1 + WIDTH + PARITY_EN. Shift register is F bits wide plus a terminator sentinel.
- FIFO push:
  - Occurs on an edge with wr_en=1 and full=0 (full taken from registered count).
  - wr_en while full: din is dropped and overflow is set; overflow clears only on reset.
- FIFO pop: only on launch.
  - Simultaneous push and pop leaves count unchanged.
  - A push into an empty FIFO is not launchable until the following edge.
- State machine IDLE -> SEND -> (GAP) -> IDLE:
  - IDLE: if count>0 and channel_busy==0 at the edge, launch.
    - Load {parity, head data, 1'b1}; pop; tx_active<=1; go to SEND.
    - serial_out=1 (start bit) during the first cycle after the launch edge.
  - SEND: shift right one bit per cycle.
    - serial_out = shift[0] & tx_active.
    - Data bits are sent LSB first, then parity if PARITY_EN.
    - channel_busy is ignored while in SEND.
    - After F cycles: tx_active<=0, frame_done pulses for one cycle, go to GAP (GAP>0) or IDLE (GAP==0).
  - GAP: down-counter from GAP; return to IDLE when it reaches 0.
    - serial_out=0 and tx_active=0 throughout.
- Parity: XOR of the data bits (even parity), so data plus parity bit has an even number of ones.
- With GAP==0 and FIFO non-empty: the next start bit follows the previous last bit after exactly one idle cycle (the IDLE launch cycle).
- With GAP==g: g+1 idle cycles between frames.
- No combinational path from din or wr_en to serial_out.

Test Plan:
- WIDTH=8, PARITY_EN=0: push 8'hA5 with channel_busy=0 -> serial_out over 9 cycles = 1,1,0,1,0,0,1,0,1; tx_active high for exactly 9 cycles; frame_done pulses once; count returns to 0.
- PARITY_EN=1: push 8'h07 -> sequence 1,1,1,1,0,0,0,0,0,1 (parity=1); push 8'hA5 -> parity bit 0.
- GAP=2: push 8'h01 and 8'h02 back-to-back -> exactly 3 idle cycles (serial_out=0, tx_active=0) between frames; tx_busy high during the 2 GAP cycles.
- Hold channel_busy=1 and push 3 flits -> no transmission, count=3. Release -> three frames in FIFO order. Assert channel_busy mid-frame -> frame completes unaltered.
- DEPTH=4: push 5 flits with channel_busy=1 -> full=1 after the 4th push; 5th dropped; overflow=1 and stays 1; the 4 queued flits are transmitted intact.
- Assert reset low at bit 4 of a frame -> serial_out, tx_active, count drop to 0 immediately. After release, a new push of 8'h3C transmits as a full, correct frame.

Source files
------------

// File: rtl/tx_buffered.sv
// Buffered serial flit transmitter: FIFO front end, start/data/parity framing,
// channel-busy gated launch and a programmable inter-frame idle gap.
module tx_buffered #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int PARITY_EN = 0,
    parameter int GAP       = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             din,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    input  logic                         channel_busy,
    output logic                         serial_out,
    output logic                         tx_active,
    output logic                         tx_busy,
    output logic                         frame_done
);

    localparam int F  = 1 + WIDTH + PARITY_EN;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [7:0] GAP_LD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] head;
    logic             push, launch, last_bit;
    logic [F:0]       shift, load_val;
    logic [7:0]       gap_cnt;

    assign full   = (count == CW'(DEPTH));
    assign push   = wr_en & ~full;
    assign launch = (state == S_IDLE) && (count != '0) && !channel_busy;
    assign head   = mem[rd_ptr];

    // Sentinel at the top marks the end: the last bit is out when only it remains above bit 0.
    assign last_bit = (shift[F:1] == F'(1));

    generate
        if (PARITY_EN != 0) begin : g_par
            assign load_val = {1'b1, ^head, head, 1'b1};
        end else begin : g_nopar
            assign load_val = {1'b1, head, 1'b1};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (launch)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !launch)
                count <= count + CW'(1);
            else if (!push && launch)
                count <= count - CW'(1);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (launch) state_nxt = S_SEND;
            S_SEND: if (last_bit) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
            S_GAP:  if (gap_cnt == 8'd0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift      <= '0;
            tx_active  <= 1'b0;
            frame_done <= 1'b0;
            gap_cnt    <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            if (launch) begin
                shift     <= load_val;
                tx_active <= 1'b1;
            end else if (state == S_SEND) begin
                if (last_bit) begin
                    shift      <= '0;
                    tx_active  <= 1'b0;
                    frame_done <= 1'b1;
                    gap_cnt    <= GAP_LD;
                end else begin
                    shift <= shift >> 1;
                end
            end else if (state == S_GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        serial_out = shift[0] & tx_active;
        tx_busy    = tx_active | channel_busy | (state == S_GAP);
    end

endmodule

// File: tb/tb_tx_buffered.sv
// Bench for tx_buffered: two instances (no parity/no gap, parity/gap 2) on one
// input stream, each checked every cycle against a frame-list reference model.
module tb_tx_buffered;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] din;
    logic       channel_busy;

    logic       full_o [2];
    logic [2:0] cnt_o [2];
    logic       ovf_o [2];
    logic       so [2];
    logic       txa [2];
    logic       txb [2];
    logic       fd [2];

    always #5 clk = ~clk;

    tx_buffered #(.WIDTH(8), .DEPTH(4), .PARITY_EN(0), .GAP(0)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din),
        .full(full_o[0]), .count(cnt_o[0]), .overflow(ovf_o[0]),
        .channel_busy(channel_busy), .serial_out(so[0]),
        .tx_active(txa[0]), .tx_busy(txb[0]), .frame_done(fd[0])
    );

    tx_buffered #(.WIDTH(8), .DEPTH(4), .PARITY_EN(1), .GAP(2)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din),
        .full(full_o[1]), .count(cnt_o[1]), .overflow(ovf_o[1]),
        .channel_busy(channel_busy), .serial_out(so[1]),
        .tx_active(txa[1]), .tx_busy(txb[1]), .frame_done(fd[1])
    );

    // Reference model: a queue of flits plus a list of the frame bits still to send.
    logic [7:0] qd [2][4];
    int         qh [2];
    int         qn [2];
    logic [8:0] pend [2];
    int         pn [2];
    int         gl [2];
    logic       act [2];
    logic       done [2];
    logic       ovf [2];
    logic       eo [2];
    logic [15:0] cap [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int i, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] got %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic model_clear(input int i);
        qh[i] = 0; qn[i] = 0; pend[i] = '0; pn[i] = 0; gl[i] = 0;
        act[i] = 1'b0; done[i] = 1'b0; ovf[i] = 1'b0; eo[i] = 1'b0;
    endtask

    task automatic model_edge(input int i);
        int gap;
        int n_pre;
        bit launch;
        logic [7:0] f;
        gap   = (i == 1) ? 2 : 0;
        n_pre = qn[i];
        if (!reset) begin
            model_clear(i);
            return;
        end
        launch  = !act[i] && gl[i] == 0 && qn[i] > 0 && !channel_busy;
        done[i] = 1'b0;
        eo[i]   = 1'b0;
        if (act[i] && pn[i] == 0) begin
            act[i]  = 1'b0;
            done[i] = 1'b1;
            gl[i]   = gap;
        end else if (act[i]) begin
            eo[i]   = pend[i][0];
            pend[i] = pend[i] >> 1;
            pn[i]--;
        end else if (launch) begin
            f       = qd[i][qh[i]];
            qh[i]   = (qh[i] + 1) % 4;
            qn[i]--;
            pend[i] = {^f, f};
            pn[i]   = 8 + i;
            eo[i]   = 1'b1;
            act[i]  = 1'b1;
        end else if (gl[i] > 0) begin
            gl[i]--;
        end
        if (wr_en) begin
            if (n_pre == 4) begin
                ovf[i] = 1'b1;
            end else begin
                qd[i][(qh[i] + qn[i]) % 4] = din;
                qn[i]++;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk("serial_out", i, 16'(so[i]), 16'(eo[i]));
            chk("tx_active", i, 16'(txa[i]), 16'(act[i]));
            chk("frame_done", i, 16'(fd[i]), 16'(done[i]));
            chk("count", i, 16'(cnt_o[i]), 16'(qn[i]));
            chk("full", i, 16'(full_o[i]), 16'(qn[i] == 4));
            chk("overflow", i, 16'(ovf_o[i]), 16'(ovf[i]));
            chk("tx_busy", i, 16'(txb[i]),
                16'(act[i] || gl[i] > 0 || channel_busy));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        @(negedge clk);
        check_all();
        for (int i = 0; i < 2; i++)
            if (txa[i]) cap[i] = {cap[i][14:0], so[i]};
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [7:0] d);
        wr_en = 1'b1;
        din   = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int k;
        int bits;
        reset = 1'b0;
        wr_en = 1'b0;
        din = 8'h00;
        channel_busy = 1'b0;
        cap[0] = '0;
        cap[1] = '0;
        model_clear(0);
        model_clear(1);
        @(negedge clk);
        check_all();
        run(2);
        reset = 1'b1;
        run(2);

        push(8'hA5);
        run(14);
        chk("frame_a5", 0, 16'(cap[0][8:0]), 16'(9'b110100101));
        chk("frame_a5", 1, 16'(cap[1][9:0]), 16'(10'b1101001010));

        push(8'h07);
        run(14);
        chk("frame_07", 0, 16'(cap[0][8:0]), 16'(9'b111100000));
        chk("frame_07", 1, 16'(cap[1][9:0]), 16'(10'b1111000001));

        push(8'h01);
        push(8'h02);
        run(30);

        channel_busy = 1'b1;
        push(8'h5A);
        push(8'hC3);
        push(8'h81);
        run(5);
        channel_busy = 1'b0;
        run(8);
        channel_busy = 1'b1;
        run(6);
        channel_busy = 1'b0;
        run(40);

        channel_busy = 1'b1;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h55);
        run(3);
        channel_busy = 1'b0;
        run(60);

        repeat (400) begin
            wr_en = ($urandom_range(0, 3) == 0);
            din = 8'($urandom);
            channel_busy = ($urandom_range(0, 4) == 0);
            step();
        end
        wr_en = 1'b0;
        channel_busy = 1'b0;
        run(60);

        push(8'hE7);
        k = 0;
        bits = 0;
        while (k < 40 && bits < 4) begin
            step();
            if (txa[0]) bits++;
            k++;
        end
        chk("reach_bit4", 0, 16'(bits), 16'(4));
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_serial_out", i, 16'(so[i]), 16'(0));
            chk("rst_tx_active", i, 16'(txa[i]), 16'(0));
            chk("rst_count", i, 16'(cnt_o[i]), 16'(0));
            model_clear(i);
        end
        run(2);
        reset = 1'b1;
        run(1);
        push(8'h3C);
        run(14);
        chk("frame_3c", 0, 16'(cap[0][8:0]), 16'(9'b100111100));
        chk("frame_3c", 1, 16'(cap[1][9:0]), 16'(10'b1001111000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
